// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch stage.
package fetch_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam word_t RESET_PC_DEF = 32'h0000_0000;
   localparam word_t PC_INC_DEF   = 32'd1;

endpackage

// File: rtl/fetch_if.sv
// Fetch stage bus: redirect input, instruction-memory port and IF/ID output handshake.
interface fetch_if;
   import fetch_pkg::*;

   logic  redirect_valid;
   word_t redirect_pc;
   word_t imem_addr;
   word_t imem_data;
   logic  out_valid;
   logic  out_ready;
   word_t out_instr;
   word_t out_pc;
   word_t out_pc_next;

   modport master (
      input  redirect_valid, redirect_pc, imem_data, out_ready,
      output imem_addr, out_valid, out_instr, out_pc, out_pc_next
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_data, out_ready,
      input  imem_addr, out_valid, out_instr, out_pc, out_pc_next
   );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register: async reset to RESET_PC, load has priority over increment.
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter word_t RESET_PC = RESET_PC_DEF,
   parameter word_t PC_INC   = PC_INC_DEF
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  load_i,
   input  word_t load_pc_i,
   input  logic  en_i,
   output word_t pc_o
);

   word_t pc_q, pc_d;

   // Increment wraps modulo 2^32 with no carry out.
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_pc_i;
      end else if (en_i) begin
         pc_d = pc_q + PC_INC;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, one-entry IF/ID output register and IDLE/RUN control.
// Defining FETCH_CNT_EN adds output fetch_count, the number of accepted output transfers.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter word_t RESET_PC = RESET_PC_DEF,
   parameter word_t PC_INC   = PC_INC_DEF
) (
   input  logic    clk,
   input  logic    rst,
   fetch_if.master bus
`ifdef FETCH_CNT_EN
   ,
   output word_t   fetch_count
`endif
);

   state_t state_q, state_d;
   logic   valid_q, valid_d;
   word_t  instr_q, instr_d;
   word_t  opc_q, opc_d;
   word_t  opcn_q, opcn_d;
   word_t  pc;
   logic   fetch;

   fetch_pc_reg #(
      .RESET_PC (RESET_PC),
      .PC_INC   (PC_INC)
   ) u_pc (
      .clk       (clk),
      .rst       (rst),
      .load_i    (bus.redirect_valid),
      .load_pc_i (bus.redirect_pc),
      .en_i      (fetch),
      .pc_o      (pc)
   );

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      instr_d = instr_q;
      opc_d   = opc_q;
      opcn_d  = opcn_q;
      fetch   = 1'b0;
      // Redirect flushes the output and suppresses the fetch, whatever the state.
      if (bus.redirect_valid) begin
         state_d = RUN;
         valid_d = 1'b0;
      end else if (state_q == IDLE) begin
         state_d = RUN;
      end else if (!valid_q || bus.out_ready) begin
         fetch   = 1'b1;
         valid_d = 1'b1;
         instr_d = bus.imem_data;
         opc_d   = pc;
         opcn_d  = pc + PC_INC;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         instr_q <= '0;
         opc_q   <= '0;
         opcn_q  <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         opc_q   <= opc_d;
         opcn_q  <= opcn_d;
      end
   end

   assign bus.imem_addr   = pc;
   assign bus.out_valid   = valid_q;
   assign bus.out_instr   = instr_q;
   assign bus.out_pc      = opc_q;
   assign bus.out_pc_next = opcn_q;

`ifdef FETCH_CNT_EN
   word_t cnt_q, cnt_d;

   // A transfer counts even when a redirect flushes the same cycle.
   assign cnt_d = (valid_q && bus.out_ready) ? cnt_q + 32'd1 : cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign fetch_count = cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter PC_INC, default 32'd1: PC increment per fetch (word-addressed instruction memory).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 redirect_valid  input  1  load new PC this cycle (branch/jump target from downstream).
REQ-006 redirect_pc  input  32  target PC, sampled when redirect_valid=1.
REQ-007 imem_addr  output  32  address to external combinational instruction memory; equals current PC register.
REQ-008 imem_data  input  32  instruction word at imem_addr, same cycle.
REQ-009 out_valid  output  1  out_instr/out_pc/out_pc_next hold a valid fetched instruction.
REQ-010 out_ready  input  1  downstream decode stage accepts the output this cycle.
REQ-011 out_instr  output  32  fetched instruction (IF/ID register).
REQ-012 out_pc  output  32  PC of out_instr.
REQ-013 out_pc_next  output  32  out_pc + PC_INC.

Function
REQ-014 State machine SHALL have two states: IDLE and RUN; reset enters IDLE.
REQ-015 IDLE SHALL last exactly one cycle, with out_valid=0 and no fetch, then go to RUN unconditionally.
REQ-016 In RUN, a fetch SHALL occur when (out_valid=0 or out_ready=1) and redirect_valid=0.
REQ-017 On fetch: out_instr<=imem_data, out_pc<=pc, out_pc_next<=pc+PC_INC, out_valid<=1, pc<=pc+PC_INC.
REQ-018 Latency SHALL be one cycle: instruction at address pc appears on out_instr the edge after pc is presented on imem_addr.
REQ-019 Stall: when out_valid=1 and out_ready=0, pc, out_instr, out_pc, out_pc_next SHALL hold unchanged.
REQ-020 Handshake: a transfer occurs on an edge where out_valid=1 and out_ready=1; out_valid SHALL NOT drop without a transfer or a redirect.
REQ-021 Redirect SHALL take priority over fetch and stall in any state: pc<=redirect_pc, out_valid<=0 (flush), no fetch that cycle; state<=RUN.
REQ-022 After a redirect, first instruction from redirect_pc SHALL be valid on out_* one edge later (one-cycle bubble).
REQ-023 PC arithmetic SHALL be 32-bit unsigned modulo 2^32; 32'hFFFF_FFFF + 1 wraps to 0 with no flag.
REQ-024 redirect_valid and out_ready both 1 in same cycle: current output is consumed, flush still applies, out_valid=0 next cycle.
REQ-025 out_ready is ignored while out_valid=0.

Reset
REQ-026 While rst=1, asynchronously: pc=RESET_PC, state=IDLE, out_valid=0, out_instr=0, out_pc=0, out_pc_next=0.
REQ-027 rst asserted mid-operation (including mid-stall or same cycle as redirect) SHALL discard all state; redirect lost.
REQ-028 First fetch after rst deasserts SHALL be from RESET_PC, on the second rising edge.

Configuration
REQ-029 Macro FETCH_CNT_EN: when defined, add output fetch_count (32 bits), incremented by 1 on every handshake transfer (REQ-020), reset to 0, wraps modulo 2^32.
REQ-030 Without FETCH_CNT_EN: port fetch_count and its counter SHALL NOT exist; all other behaviour identical.

Structure
REQ-031 Shared package fetch_pkg SHALL hold the state enum (IDLE, RUN), the 32-bit word typedef, and the default RESET_PC/PC_INC constants.
REQ-032 One sub-module fetch_pc_reg (PC register with async reset, load, enable) is natural; IF/ID output register and FSM stay in fetch_stage.

Verification
REQ-033 Reset release, out_ready=1, imem returns mem[a]=a+32'h100 -> out_valid rises edge 2; out_pc sequence 0,1,2,3; out_instr 0x100,0x101,...
REQ-034 Stall: out_ready=0 for 3 cycles while out_pc=5 -> out_pc=5, out_instr, imem_addr=6 stable for 3 cycles; resume gives out_pc 6 next.
REQ-035 Redirect: redirect_valid=1, redirect_pc=0x40 while out_pc=3 -> next cycle out_valid=0, imem_addr=0x40; following cycle out_pc=0x40, out_pc_next=0x41.
REQ-036 Wrap: redirect_pc=0xFFFF_FFFF -> out_pc=0xFFFF_FFFF with out_pc_next=0, then out_pc=0.
REQ-037 rst pulse mid-stall with redirect_valid=1 -> outputs 0, out_valid=0, next fetch from RESET_PC.
REQ-038 FETCH_CNT_EN defined, 10 transfers interleaved with 4 stall cycles and 1 redirect -> fetch_count=10.
